llc_port_arb: RTL and testbench
===============================

Name: llc_port_arb

Overview:
- Shares one LLC request/response lane among N_REQ requesters, e.g. core-side agents ahead of a single port of the LLC proxy.
- Grants requesters round-robin and keeps exactly one transaction outstanding on the lane.
- Records the grant owner and routes the LLC reply back to that owner only.
- Sits between the requester fabric and one lane of the LLC valid/ready interface.

Parameters:
- DATA_W, 64, width of request and response payloads.
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, owner index width; must satisfy 2**ID_W >= N_REQ.
- TO_CYC, 16, WAIT-state timeout in cycles (used only with LLC_ARB_TIMEOUT_EN); range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_v  in  N_REQ  per-requester request valid.
- req_r  out  N_REQ  per-requester request ready (one-hot or zero).
- req_d  in  N_REQ*DATA_W  packed request payloads; lane i at [DATA_W*(i+1)-1:DATA_W*i].
- rsp_v  out  N_REQ  per-requester response valid (one-hot or zero).
- rsp_r  in  N_REQ  per-requester response ready.
- rsp_d  out  DATA_W  response payload, broadcast to all requesters.
- rsp_err  out  1  response is a timeout error; qualified by rsp_v.
- llc_so  out  1  request valid to LLC.
- llc_ro  in  1  LLC request ready.
- llc_do  out  DATA_W  request payload to LLC.
- llc_si_r  in  1  LLC reply valid.
- llc_ri_r  out  1  reply ready to LLC.
- llc_di_r  in  DATA_W  LLC reply payload.
- owner  out  ID_W  index of the current grant owner.
- busy  out  1  high whenever state != IDLE.
- err_flag  out  1  sticky timeout indicator.

Behaviour:
- Reset (asynchronous): state=IDLE, ptr=0, owner=0, payload registers=0, stale=0, err_flag=0. Output values under reset:
  - req_r=0, rsp_v=0, rsp_err=0.
  - llc_so=0, llc_ri_r=0, busy=0.
  - llc_do=0, rsp_d=0.
- Reset asserted mid-transaction aborts the transaction silently; no response is delivered.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_v[i]=1, scanning ptr, ptr+1, ..., wrapping modulo N_REQ.
  - req_r = onehot(winner) combinationally, only in IDLE. The handshake completes in this cycle.
  - On the edge: latch req_d lane of winner, set owner=winner, go to ISSUE.
  - If no req_v is set, stay in IDLE.
- ISSUE:
  - llc_so=1 and llc_do = latched payload, both held stable.
  - When llc_ro=1 (handshake) go to WAIT; otherwise stay.
- WAIT:
  - llc_ri_r=1.
  - When llc_si_r=1: latch llc_di_r, set rsp_err=0, go to RESP.
- RESP:
  - rsp_v = onehot(owner); rsp_d and rsp_err come from registers and are held stable.
  - When rsp_r[owner]=1: ptr = (owner+1) mod N_REQ, go to IDLE.
  - rsp_r of non-owners is ignored.
- llc_ri_r=0 outside WAIT. A reply arriving outside WAIT stays pending at the LLC and is never dropped by the arbiter.
- Minimum latency with zero-latency LLC and always-ready consumer: accept at T, llc_so at T+1, WAIT at T+2, reply seen T+2, rsp_v at T+3.
- Back-to-back: a new grant can occur in the cycle after the RESP handshake; there is no IDLE bypass.
- Fairness: the owner just served has the lowest priority in the next arbitration.

Optional Feature:
- Macro: LLC_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without llc_si_r.
  - When it reaches TO_CYC: go to RESP with rsp_d={DATA_W{1'b1}}, rsp_err=1; set err_flag=1 and stale=1.
  - While stale=1, the next reply handshake in WAIT is discarded, clears stale, and does not leave WAIT; the timeout counter restarts.
  - If llc_si_r arrives in the same cycle the count hits TO_CYC, the reply wins and there is no timeout.
- Without the macro: WAIT is unbounded; rsp_err, err_flag and stale are tied to 0; the counter logic is absent.

Decomposition:
- Package llc_arb_pkg holds:
  - the state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - the ERR_PATTERN constant;
  - the counter width constant (8).
- One sub-module: rr_pick. It is combinational, takes inputs req_v[N_REQ] and ptr[ID_W], and outputs gnt_onehot, gnt_idx and any.

Test Plan:
- Single requester: N_REQ=4, req_v=4'b0100, req_d lane2=64'hA5, LLC latency 3 -> exactly one llc_so with llc_do=64'hA5; rsp_v=4'b0100, rsp_d equals the LLC reply, owner=2.
- Full contention: req_v=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no requester is granted twice in a row.
- Backpressure: llc_ro low for 5 cycles, then rsp_r[owner] low for 4 cycles -> llc_so/llc_do and rsp_v/rsp_d held stable throughout; no second grant occurs.
- Stray reply: llc_si_r high while in ISSUE -> llc_ri_r=0; the reply is consumed only after WAIT is entered.
- Async reset (reset=0) asserted mid-WAIT -> all outputs 0 immediately; after release, ptr=0 and req_v=4'b1000 is granted normally.
- LLC_ARB_TIMEOUT_EN defined, TO_CYC=4, LLC never replies -> rsp_v after 4 WAIT cycles with rsp_err=1, rsp_d=all ones, err_flag=1. The late reply is discarded; the next transaction receives the correct data.

Source files
------------

// File: rtl/llc_arb_pkg.sv
// ============================================================================
// Module      : llc_arb_pkg
// Description : Shared FSM encoding and constants for the LLC port arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package llc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Wide enough for any supported payload; callers slice to DATA_W.
    localparam logic [255:0] ERR_PATTERN = '1;

    localparam int CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/llc_port_arb_if.sv
// ============================================================================
// Module      : llc_port_arb_if
// Description : Requester-side and LLC-side handshake bundle of one arbiter lane.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface llc_port_arb_if #(
    parameter int DATA_W = 64,
    parameter int N_REQ  = 4
);
    logic [N_REQ-1:0]        req_v;
    logic [N_REQ-1:0]        req_r;
    logic [N_REQ*DATA_W-1:0] req_d;
    logic [N_REQ-1:0]        rsp_v;
    logic [N_REQ-1:0]        rsp_r;
    logic [DATA_W-1:0]       rsp_d;
    logic                    rsp_err;
    logic                    llc_so;
    logic                    llc_ro;
    logic [DATA_W-1:0]       llc_do;
    logic                    llc_si_r;
    logic                    llc_ri_r;
    logic [DATA_W-1:0]       llc_di_r;

    modport slave (
        input  req_v, req_d, rsp_r, llc_ro, llc_si_r, llc_di_r,
        output req_r, rsp_v, rsp_d, rsp_err, llc_so, llc_do, llc_ri_r
    );

    modport master (
        output req_v, req_d, rsp_r, llc_ro, llc_si_r, llc_di_r,
        input  req_r, rsp_v, rsp_d, rsp_err, llc_so, llc_do, llc_ri_r
    );
endinterface

`default_nettype wire

// File: rtl/llc_port_arb_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first set request at or after ptr.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_v,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]  gnt_idx,
    output logic             any
);

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return s[ID_W-1:0];
    endfunction

    // Scan from farthest to nearest so the candidate closest to ptr wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_v[wrap_add(ptr, k)]) begin
                gnt_idx = wrap_add(ptr, k);
                any     = 1'b1;
            end
        end
    end

    assign gnt_onehot = any ? (N_REQ'(1) << gnt_idx) : '0;

endmodule

`default_nettype wire

// File: rtl/llc_port_arb.sv
// ============================================================================
// Module      : llc_port_arb
// Description : Round-robin arbiter sharing one LLC lane, one transaction in flight.
//               Optional WAIT timeout enabled by macro LLC_ARB_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module llc_port_arb
    import llc_arb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int TO_CYC = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    llc_port_arb_if.slave     bus,
    output logic [ID_W-1:0]   owner,
    output logic              busy,
    output logic              err_flag
);

    if ((2 ** ID_W) < N_REQ || N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("llc_port_arb: N_REQ/ID_W out of range");
    end
    if (TO_CYC < 1 || TO_CYC > 255) begin : g_bad_to
        $error("llc_port_arb: TO_CYC out of range");
    end

    arb_state_t        r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_owner;
    logic [DATA_W-1:0] r_req_data;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_llc_so;
    logic              r_llc_ri;
    logic [N_REQ-1:0]  r_rsp_v;
    logic              r_busy;

    logic [N_REQ-1:0]  w_gnt_oh;
    logic [ID_W-1:0]   w_gnt_idx;
    logic              w_any;
    logic [DATA_W-1:0] w_lane;
    logic [N_REQ-1:0]  w_owner_oh;
    logic [ID_W-1:0]   w_ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_v      (bus.req_v),
        .ptr        (r_ptr),
        .gnt_onehot (w_gnt_oh),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    assign w_lane     = bus.req_d[DATA_W*int'(w_gnt_idx) +: DATA_W];
    assign w_owner_oh = N_REQ'(1) << r_owner;
    assign w_ptr_next = (int'(r_owner) == N_REQ - 1) ? '0 : r_owner + 1'b1;

`ifdef LLC_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TO_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_stale;
    logic             r_rsp_err;
    logic             r_err_flag;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_req_data <= '0;
            r_rsp_data <= '0;
            r_llc_so   <= 1'b0;
            r_llc_ri   <= 1'b0;
            r_rsp_v    <= '0;
            r_busy     <= 1'b0;
`ifdef LLC_ARB_TIMEOUT_EN
            r_cnt      <= '0;
            r_stale    <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_err_flag <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_req_data <= w_lane;
                        r_owner    <= w_gnt_idx;
                        r_llc_so   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.llc_ro) begin
                        r_llc_so <= 1'b0;
                        r_llc_ri <= 1'b1;
                        r_state  <= WAIT;
`ifdef LLC_ARB_TIMEOUT_EN
                        r_cnt    <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (bus.llc_si_r) begin
`ifdef LLC_ARB_TIMEOUT_EN
                        // Late reply of a timed-out transaction: swallow it and keep waiting.
                        if (r_stale) begin
                            r_stale <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_rsp_err <= 1'b0;
`else
                        begin
`endif
                            r_rsp_data <= bus.llc_di_r;
                            r_llc_ri   <= 1'b0;
                            r_rsp_v    <= w_owner_oh;
                            r_state    <= RESP;
                        end
                    end
`ifdef LLC_ARB_TIMEOUT_EN
                    else if (r_cnt == c_TO_LAST) begin
                        r_rsp_data <= ERR_PATTERN[DATA_W-1:0];
                        r_rsp_err  <= 1'b1;
                        r_err_flag <= 1'b1;
                        r_stale    <= 1'b1;
                        r_llc_ri   <= 1'b0;
                        r_rsp_v    <= w_owner_oh;
                        r_state    <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus.rsp_r[r_owner]) begin
                        r_ptr   <= w_ptr_next;
                        r_rsp_v <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Gating with reset keeps req_r low while reset is asserted.
    assign bus.req_r    = (reset && r_state == IDLE) ? w_gnt_oh : '0;
    assign bus.rsp_v    = r_rsp_v;
    assign bus.rsp_d    = r_rsp_data;
    assign bus.llc_so   = r_llc_so;
    assign bus.llc_do   = r_req_data;
    assign bus.llc_ri_r = r_llc_ri;
    assign owner        = r_owner;
    assign busy         = r_busy;

`ifdef LLC_ARB_TIMEOUT_EN
    assign bus.rsp_err = r_rsp_err;
    assign err_flag    = r_err_flag;
`else
    assign bus.rsp_err = 1'b0;
    assign err_flag    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_llc_port_arb.sv
// ============================================================================
// Module      : tb_llc_port_arb
// Description : Scoreboard bench for llc_port_arb; timeout scenario under LLC_ARB_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_llc_port_arb;

`ifdef LLC_ARB_TIMEOUT_EN
    localparam int C_TO = 4;
`else
    localparam int C_TO = 16;
`endif
    localparam logic [63:0] C_RKEY = 64'hF0F0_1234_0F0F_5678;

    logic       clk;
    logic       reset;
    logic [1:0] owner;
    logic       busy;
    logic       err_flag;

    llc_port_arb_if #(.DATA_W(64), .N_REQ(4)) bus ();

    llc_port_arb #(
        .DATA_W (64),
        .N_REQ  (4),
        .ID_W   (2),
        .TO_CYC (C_TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .owner    (owner),
        .busy     (busy),
        .err_flag (err_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors;
    int          checks;
    int          tb_ptr;
    int          last_grant;
    logic [63:0] lanes [4];
    int          exp_owner_q[$];
    logic [63:0] exp_data_q[$];
    logic        exp_err_q[$];

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int t);
        for (int i = 0; i < 4; i++) begin
            lanes[i] = {32'hC0DE_0000 + 32'(t), 32'h0000_1000 + 32'(i)};
            bus.req_d[i*64 +: 64] = lanes[i];
        end
    endtask

    // One complete transaction; the expected result is queued at grant time.
    task automatic do_txn(input logic [3:0] reqs, input bit hold, input int ro_dly,
                          input int rep_dly, input int rsp_dly, input bit stray,
                          input bit stale_first);
        int          exp_idx;
        int          n;
        int          o;
        logic [63:0] pay;
        logic [63:0] rep;
        logic [63:0] ed;
        logic        ee;
        logic [3:0]  ooh;
        exp_idx = -1;
        for (int k = 0; k < 4; k++)
            if (exp_idx < 0 && reqs[(tb_ptr + k) % 4]) exp_idx = (tb_ptr + k) % 4;
        bus.req_v = reqs;
        #1;
        n = 0;
        while (bus.req_r == 4'b0 && n < 20) begin next_cycle(); n++; end
        checks++;
        if (bus.req_r !== 4'(1 << exp_idx)) begin
            errors++;
            $display("FAIL grant: req_r=%b expected=%b", bus.req_r, 4'(1 << exp_idx));
        end
        if (bus.req_r == 4'b0) begin bus.req_v = '0; return; end
        last_grant = 0;
        for (int i = 0; i < 4; i++) if (bus.req_r[i]) last_grant = i;
        pay = lanes[exp_idx];
        rep = pay ^ C_RKEY;
        exp_owner_q.push_back(exp_idx);
        exp_data_q.push_back(rep);
        exp_err_q.push_back(1'b0);
        if (stray) begin bus.llc_si_r = 1'b1; bus.llc_di_r = rep; end
        next_cycle();
        if (!hold) bus.req_v = '0;
        for (int c = 0; c <= ro_dly; c++) begin
            bus.llc_ro = (c == ro_dly);
            #1;
            checks++;
            if (bus.llc_so !== 1'b1 || bus.llc_do !== pay || bus.req_r !== 4'b0) begin
                errors++;
                $display("FAIL issue: so=%b do=%h req_r=%b expected so=1 do=%h req_r=0",
                         bus.llc_so, bus.llc_do, bus.req_r, pay);
            end
            if (stray) begin
                checks++;
                if (bus.llc_ri_r !== 1'b0) begin
                    errors++;
                    $display("FAIL stray_ready: llc_ri_r=%b expected=0", bus.llc_ri_r);
                end
            end
            next_cycle();
        end
        bus.llc_ro = 1'b0;
        for (int c = 0; c <= rep_dly; c++) begin
            if (c == rep_dly) begin
                bus.llc_si_r = 1'b1; bus.llc_di_r = rep;
            end else if (stale_first && c == 0) begin
                bus.llc_si_r = 1'b1; bus.llc_di_r = 64'hBAD0_BAD0_BAD0_BAD0;
            end else begin
                bus.llc_si_r = 1'b0;
            end
            #1;
            checks++;
            if (bus.llc_ri_r !== 1'b1 || bus.llc_so !== 1'b0) begin
                errors++;
                $display("FAIL wait: ri=%b so=%b expected ri=1 so=0", bus.llc_ri_r, bus.llc_so);
            end
            next_cycle();
        end
        bus.llc_si_r = 1'b0;
        bus.llc_di_r = '0;
        n = 0;
        while (bus.rsp_v == 4'b0 && n < 20) begin next_cycle(); n++; end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL rsp_latency: extra_cycles=%0d expected=0", n);
        end
        o   = exp_owner_q.pop_front();
        ed  = exp_data_q.pop_front();
        ee  = exp_err_q.pop_front();
        ooh = 4'(1 << o);
        for (int c = 0; c <= rsp_dly; c++) begin
            bus.rsp_r = (c == rsp_dly) ? ooh : ~ooh;
            #1;
            checks++;
            if (bus.rsp_v !== ooh || bus.rsp_d !== ed || bus.rsp_err !== ee || owner !== 2'(o)) begin
                errors++;
                $display("FAIL resp: v=%b d=%h err=%b owner=%0d expected v=%b d=%h err=%b owner=%0d",
                         bus.rsp_v, bus.rsp_d, bus.rsp_err, owner, ooh, ed, ee, o);
            end
            next_cycle();
        end
        bus.rsp_r = '0;
        #1;
        checks++;
        if (bus.rsp_v !== 4'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release: rsp_v=%b busy=%b expected 0 0", bus.rsp_v, busy);
        end
        tb_ptr = (o + 1) % 4;
    endtask

    task automatic test_reset;
        bus.req_v = 4'b1111;
        #1;
        checks++;
        if (bus.req_r !== 4'b0 || bus.rsp_v !== 4'b0 || bus.rsp_err !== 1'b0 ||
            bus.llc_so !== 1'b0 || bus.llc_ri_r !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req_r=%b rsp_v=%b err=%b so=%b ri=%b busy=%b expected all 0",
                     bus.req_r, bus.rsp_v, bus.rsp_err, bus.llc_so, bus.llc_ri_r, busy);
        end
        checks++;
        if (bus.llc_do !== 64'h0 || bus.rsp_d !== 64'h0 || owner !== 2'd0 || err_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: do=%h rsp_d=%h owner=%0d err_flag=%b expected all 0",
                     bus.llc_do, bus.rsp_d, owner, err_flag);
        end
        bus.req_v = '0;
        reset = 1'b1;
        next_cycle();
        tb_ptr = 0;
    endtask

    task automatic test_back_to_back;
        int order [8];
        for (int t = 0; t < 8; t++) begin
            set_lanes(t);
            do_txn(4'b1111, 1'b1, 0, 0, 0, 1'b0, 1'b0);
            order[t] = last_grant;
        end
        bus.req_v = '0;
        for (int t = 0; t < 8; t++) begin
            checks++;
            if (order[t] != t % 4) begin
                errors++;
                $display("FAIL rr_order[%0d]: granted=%0d expected=%0d", t, order[t], t % 4);
            end
        end
        next_cycle();
    endtask

    task automatic test_single;
        set_lanes(10);
        lanes[2] = 64'hA5;
        bus.req_d[2*64 +: 64] = lanes[2];
        do_txn(4'b0100, 1'b0, 0, 3, 0, 1'b0, 1'b0);
        next_cycle();
    endtask

    task automatic test_backpressure;
        set_lanes(11);
        do_txn(4'b0011, 1'b1, 5, 1, 4, 1'b0, 1'b0);
        bus.req_v = '0;
        next_cycle();
    endtask

    task automatic test_stray;
        set_lanes(12);
        do_txn(4'b0010, 1'b0, 2, 0, 1, 1'b1, 1'b0);
        next_cycle();
    endtask

    task automatic test_async_reset;
        int n;
        set_lanes(13);
        bus.req_v = 4'b0001;
        #1;
        n = 0;
        while (bus.req_r == 4'b0 && n < 20) begin next_cycle(); n++; end
        next_cycle();
        bus.req_v  = 4'b1111;
        bus.llc_ro = 1'b1;
        next_cycle();
        bus.llc_ro = 1'b0;
        #1;
        checks++;
        if (bus.llc_ri_r !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_wait: llc_ri_r=%b expected=1", bus.llc_ri_r);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req_r !== 4'b0 || bus.rsp_v !== 4'b0 || bus.llc_so !== 1'b0 || bus.llc_ri_r !== 1'b0 ||
            busy !== 1'b0 || bus.llc_do !== 64'h0 || bus.rsp_d !== 64'h0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: req_r=%b rsp_v=%b so=%b ri=%b busy=%b do=%h rsp_d=%h owner=%0d expected all 0",
                     bus.req_r, bus.rsp_v, bus.llc_so, bus.llc_ri_r, busy, bus.llc_do, bus.rsp_d, owner);
        end
        bus.req_v = '0;
        exp_owner_q.delete();
        exp_data_q.delete();
        exp_err_q.delete();
        tb_ptr = 0;
        next_cycle();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            checks++;
            if (bus.rsp_v !== 4'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL aborted_silent: rsp_v=%b busy=%b expected 0 0", bus.rsp_v, busy);
            end
        end
        set_lanes(14);
        do_txn(4'b1000, 1'b0, 0, 1, 0, 1'b0, 1'b0);
        set_lanes(15);
        do_txn(4'b1001, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        next_cycle();
    endtask

`ifdef LLC_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int          n;
        int          o;
        logic [63:0] ed;
        logic        ee;
        set_lanes(20);
        bus.req_v = 4'b0001;
        #1;
        n = 0;
        while (bus.req_r == 4'b0 && n < 20) begin next_cycle(); n++; end
        exp_owner_q.push_back(0);
        exp_data_q.push_back('1);
        exp_err_q.push_back(1'b1);
        next_cycle();
        bus.req_v  = '0;
        bus.llc_ro = 1'b1;
        next_cycle();
        bus.llc_ro = 1'b0;
        n = 0;
        while (bus.llc_ri_r === 1'b1 && n < 50) begin next_cycle(); n++; end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL to_wait_cycles: got=%0d expected=4", n);
        end
        o  = exp_owner_q.pop_front();
        ed = exp_data_q.pop_front();
        ee = exp_err_q.pop_front();
        checks++;
        if (bus.rsp_v !== 4'(1 << o) || bus.rsp_d !== ed || bus.rsp_err !== ee || err_flag !== 1'b1) begin
            errors++;
            $display("FAIL to_resp: v=%b d=%h err=%b flag=%b expected v=%b d=%h err=%b flag=1",
                     bus.rsp_v, bus.rsp_d, bus.rsp_err, err_flag, 4'(1 << o), ed, ee);
        end
        bus.rsp_r = 4'(1 << o);
        next_cycle();
        bus.rsp_r = '0;
        tb_ptr = 1;
        set_lanes(21);
        do_txn(4'b0010, 1'b0, 0, 2, 0, 1'b0, 1'b1);
        checks++;
        if (err_flag !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err_flag=%b expected=1", err_flag);
        end
        next_cycle();
    endtask
`endif

    initial begin
        errors       = 0;
        checks       = 0;
        tb_ptr       = 0;
        last_grant   = 0;
        reset        = 1'b0;
        bus.req_v    = '0;
        bus.req_d    = '0;
        bus.rsp_r    = '0;
        bus.llc_ro   = 1'b0;
        bus.llc_si_r = 1'b0;
        bus.llc_di_r = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_single();
        test_backpressure();
        test_stray();
        test_async_reset();
`ifdef LLC_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
